// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run sequencer.
package run_seq_pkg;

  localparam int CYC_W          = 16;
  localparam int RST_CYCLES_DEF = 2;
  localparam int PROG_CNT_DEF   = 3;
  localparam int MAX_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear and count enable.
module run_cycle_counter
  import run_seq_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  output logic [CYC_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != {CYC_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Core run controller: reset hold, run, halt/done reporting and program selection.
// Optional watchdog compiled in with RUN_SEQ_WATCHDOG_EN.
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// RESET | core held in reset for RST_CYCLES cycles
// RUN   | core executing, cycles counted
// DONE  | core frozen, results readable, prog_sel advanced
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int PROG_CNT   = PROG_CNT_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  output logic             core_reset,
  output logic             core_run,
  output logic [1:0]       prog_sel,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count
);

`ifdef RUN_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES - 1);
  localparam logic [1:0]       PROG_MAX = 2'(PROG_CNT - 1);
  localparam logic [CYC_W-1:0] WD_LIMIT = CYC_W'(MAX_CYCLES - 1);

  run_state_t      state;
  logic [RC_W-1:0] rst_cnt;
  logic            timeout_q;
  logic            enter_reset;
  logic            wd_hit;

  assign enter_reset = ((state == IDLE) || (state == DONE)) && start;
  // Halt takes priority: the watchdog only fires on a cycle without halt.
  assign wd_hit      = WD_EN && !halt && (cycle_count == WD_LIMIT);
  assign timeout     = WD_EN ? timeout_q : 1'b0;

  run_cycle_counter u_cycle_counter (
    .clock  (clock),
    .clear  (reset || enter_reset),
    .enable (state == RUN),
    .count  (cycle_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      core_reset <= 1'b1;
      core_run   <= 1'b0;
      done       <= 1'b0;
      timeout_q  <= 1'b0;
      prog_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RESET;
            rst_cnt <= RC_LOAD;
          end
        end
        RESET: begin
          if (rst_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            core_run   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          if (halt || wd_hit) begin
            state     <= DONE;
            core_run  <= 1'b0;
            done      <= 1'b1;
            timeout_q <= !halt;
            prog_sel  <= (prog_sel == PROG_MAX) ? 2'd0 : prog_sel + 2'd1;
          end
        end
        DONE: begin
          if (start) begin
            state      <= RESET;
            rst_cnt    <= RC_LOAD;
            core_reset <= 1'b1;
            done       <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          core_run   <= 1'b0;
          done       <= 1'b0;
          timeout_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer: the driver queues the expected end-of-run
// results, and a monitor compares them whenever done rises.
module tb_run_sequencer;

  localparam int RST_CYC  = 2;
  localparam int PROG_CNT = 3;
  localparam int MAX_CYC  = 16;

  logic        clock;
  logic        reset;
  logic        start;
  logic        halt;
  logic        core_reset;
  logic        core_run;
  logic [1:0]  prog_sel;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  typedef struct {
    int count;
    int prog;
    int to;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_prog = 0;
  logic done_q;

  run_sequencer #(
    .RST_CYCLES (RST_CYC),
    .PROG_CNT   (PROG_CNT),
    .MAX_CYCLES (MAX_CYC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .core_reset  (core_reset),
    .core_run    (core_run),
    .prog_sel    (prog_sel),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome of a run whose halt arrives on RUN cycle k (1-based).
  task automatic push_run(input int k);
    exp_t e;
    e.count = k;
    e.to    = 0;
`ifdef RUN_SEQ_WATCHDOG_EN
    if (k > MAX_CYC) begin
      e.count = MAX_CYC;
      e.to    = 1;
    end
`endif
    model_prog = (model_prog + 1) % PROG_CNT;
    e.prog     = model_prog;
    q.push_back(e);
  endtask

  // Precondition: at a negedge with the DUT in IDLE or DONE.
  task automatic run_once(input int k, input bit keep);
    int i;
    start = 1'b1;
    push_run(k);
    for (int r = 0; r < RST_CYC; r++) begin
      @(negedge clock);
      start = keep ? 1'b1 : 1'($urandom_range(1, 0));
      chk("rst_hold", int'({core_reset, core_run}), 2);
      if (r == 0) chk("done_cleared", int'({done, timeout}), 0);
    end
    @(negedge clock);
    chk("run_rise", int'({core_reset, core_run}), 1);
    i = 1;
    forever begin
      halt  = (i == k);
      start = keep ? 1'b1 : 1'($urandom_range(1, 0));
      @(negedge clock);
      if (!core_run) break;
      i++;
      if (i > k + 4) begin
        chk("run_stuck", int'(core_run), 0);
        break;
      end
    end
    halt  = 1'b0;
    start = keep;
  endtask

  // Monitor: compare queued expectations on each rising edge of done.
  initial begin
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        done_q = 1'b0;
      end else begin
        if (done && !done_q) begin
          if (q.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
          end else begin
            e = q.pop_front();
            chk("cycle_count", int'(cycle_count), e.count);
            chk("prog_sel", int'(prog_sel), e.prog);
            chk("timeout", int'(timeout), e.to);
            chk("done_frozen", int'({core_reset, core_run}), 0);
          end
        end
        done_q = done;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    halt  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_core_reset", int'(core_reset), 1);
    chk("rst_core_run", int'(core_run), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_cycle_count", int'(cycle_count), 0);
    chk("rst_prog_sel", int'(prog_sel), 0);
    reset = 1'b0;
    @(negedge clock);

    // Halt while idle is ignored.
    halt = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("idle_halt", int'({done, core_run, core_reset}), 1);
    end
    halt = 1'b0;

    run_once(10, 1'b0);
    repeat (2) @(negedge clock);

    // Back-to-back runs with start held high.
    for (int n = 0; n < 3; n++) run_once(int'($urandom_range(12, 1)), n < 2);
    repeat (3) @(negedge clock);

    run_once(MAX_CYC, 1'b0);
    @(negedge clock);
    run_once(MAX_CYC + 3, 1'b0);

    for (int n = 0; n < 20; n++) begin
      bit keep;
      keep = 1'($urandom_range(1, 0));
      run_once(int'($urandom_range(30, 1)), keep);
      if (!keep) repeat ($urandom_range(3, 0)) @(negedge clock);
    end
    start = 1'b0;
    repeat (3) @(negedge clock);

    // Reset during RUN cycle 5.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (RST_CYC + 4) @(negedge clock);
    chk("mid_run_active", int'(core_run), 1);
    reset = 1'b1;
    model_prog = 0;
    @(negedge clock);
    chk("mid_rst_core_reset", int'(core_reset), 1);
    chk("mid_rst_core_run", int'(core_run), 0);
    chk("mid_rst_cycle_count", int'(cycle_count), 0);
    chk("mid_rst_prog_sel", int'(prog_sel), 0);
    chk("mid_rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clock);

    run_once(7, 1'b0);
    repeat (5) @(negedge clock);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run controller for the single-cycle 9-bit core. Accepts a `start` request from the test harness and drives the core's `reset` for a fixed number of cycles. It then enables execution, watches the decoded halt indication, and reports `done` along with a cycle count. Each completed run advances a program-select index, so one bench invocation can execute several programs back to back.

## Interface
Parameters:
- `RST_CYCLES`, default 2: cycles `core_reset` is held after a start is accepted (≥1).
- `PROG_CNT`, default 3: number of programs; `prog_sel` wraps modulo this value (1..4).
- `MAX_CYCLES`, default 4096: watchdog limit in RUN cycles (only used with the watchdog compiled in).

Ports:
- `clock` input 1: the single clock; everything is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: level run request; sampled only in IDLE or DONE.
- `halt` input 1: halt instruction decoded by control in the current cycle.
- `core_reset` output 1: drives the PC/core reset.
- `core_run` output 1: enable for PC advance, register writes and data-memory writes.
- `prog_sel` output 2: program index for instruction-ROM bank selection.
- `done` output 1: run finished; results stable.
- `timeout` output 1: the last run ended on the watchdog, not on halt.
- `cycle_count` output 16: RUN cycles executed in the current or last run.

## Operation
- States: IDLE, RESET, RUN, DONE.
- `reset` forces IDLE, with `core_reset`=1, `core_run`=0, `done`=0, `timeout`=0, `cycle_count`=0, `prog_sel`=0.
- **IDLE**: `core_reset`=1, `core_run`=0. If `start`=1, go to RESET and load the reset counter with RST_CYCLES-1.
- **RESET**: `core_reset`=1, `core_run`=0, `cycle_count` cleared. The counter decrements each cycle; at 0, go to RUN.
- **RUN**: `core_reset`=0, `core_run`=1. `cycle_count` increments every RUN cycle, including the halt cycle, and saturates at 16'hFFFF. If `halt`=1, go to DONE.
- **DONE**: `core_reset`=0, `core_run`=0, so the core is frozen and memory stays readable. `done`=1. On entry, `prog_sel` advances: if `prog_sel`=PROG_CNT-1 it becomes 0, else it increments by 1. If `start`=1, go to RESET; `done` and `timeout` clear as RESET is entered.
- `start` is ignored in RESET and RUN. A `halt` outside RUN is ignored.
- `start` held high continuously chains runs back to back, with one DONE cycle between runs.

## Timing
- `start` is sampled in IDLE at edge N. `core_reset` stays 1 through cycle N+RST_CYCLES. The first RUN cycle, with `core_run`=1 and PC=0, is N+RST_CYCLES+1.
- A `halt` sampled at edge M in RUN means the halt instruction's cycle is the last executed. At M+1: `core_run`=0, `done`=1, `prog_sel` updated, `cycle_count` final.
- All outputs are registered; none depend combinationally on `start` or `halt`.
- Reset in the middle of any state returns to IDLE reset values on the next edge. `prog_sel` also returns to 0.

## Configuration
- `RUN_SEQ_WATCHDOG_EN` defined: in RUN, if `cycle_count` reaches MAX_CYCLES-1 and `halt`=0, go to DONE with `timeout`=1. If `halt` and the watchdog limit occur in the same cycle, halt wins and `timeout`=0.
- `RUN_SEQ_WATCHDOG_EN` undefined: a run ends only on `halt`. `timeout` is tied to 0 and MAX_CYCLES is unused.

## Structure
- Package `run_seq_pkg` holds:
  - the state enum typedef `run_state_t` (IDLE, RESET, RUN, DONE);
  - localparam `CYC_W`=16;
  - the default values for RST_CYCLES, PROG_CNT and MAX_CYCLES.
- Sub-module `run_cycle_counter` is a 16-bit saturating counter with synchronous clear and enable. It is reused for `cycle_count`.
- The reset-hold count is a small counter inline in the FSM.

## Test plan
- Reset then `start`=1 for one cycle (RST_CYCLES=2) -> `core_reset`=1 for exactly 2 cycles after acceptance; `core_run` rises on the 3rd cycle after acceptance.
- `halt`=1 on the 10th RUN cycle -> next cycle `done`=1, `core_run`=0, `cycle_count`=10, `prog_sel`=1, `timeout`=0.
- `start` held high across 3 runs (PROG_CNT=3) -> `prog_sel` goes 1, 2, 0; `done` pulses once per run; `cycle_count` clears in each RESET.
- With watchdog, MAX_CYCLES=16, `halt` never asserted -> after RUN cycle 16, `done`=1, `timeout`=1, `cycle_count`=16. With `halt` on cycle 16 -> `timeout`=0.
- Pulse `start` during RUN, and `halt` while in IDLE -> no state change and no `done`.
- Assert `reset` on RUN cycle 5 -> next cycle IDLE with `core_reset`=1, `cycle_count`=0, `prog_sel`=0, `done`=0.
